// File: rtl/output_backprop.sv
// Output-neuron weight update: err = final - target, g_k = err * x_k, and
// w_k -= g_k >>> LR_SHIFT with the result clamped to the unsigned 8-bit range.
module output_backprop #(
    parameter int unsigned LR_SHIFT = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [22:0] final_i,
    input  logic [3:0]  init_i,
    input  logic [9:0]  x0_i,
    input  logic [9:0]  x1_i,
    input  logic [7:0]  w0_i,
    input  logic [7:0]  w1_i,
    output logic [7:0]  w0_o,
    output logic [7:0]  w1_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        sat_o
);

    localparam int unsigned FINAL_W = 23;
    localparam int unsigned TGT_W   = 4;
    localparam int unsigned X_W     = 10;
    localparam int unsigned W_W     = 8;
    localparam int unsigned ERR_W   = 24;
    localparam int unsigned G_W     = 35;
    localparam int unsigned ACC_W   = 36;

    localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'(255);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_GRAD0,
        S_GRAD1,
        S_UPD,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic cap_en, err_en, g0_en, g1_en, upd_en, pass_en;

    logic [FINAL_W-1:0] final_q;
    logic [TGT_W-1:0]   init_q;
    logic [X_W-1:0]     x0_q, x1_q;
    logic [W_W-1:0]     w0_q, w1_q;

    logic signed [ERR_W-1:0] err_c, err_q;
    logic [X_W-1:0]          mul_x_c;
    logic signed [G_W-1:0]   prod_c, g0_q, g1_q;
    logic signed [G_W-1:0]   d0_c, d1_c;
    logic signed [ACC_W-1:0] w0_new_c, w1_new_c;
    logic [W_W:0]            w0_cl_c, w1_cl_c;

    // Clamp to 0..255; MSB of the return value flags that clamping happened.
    function automatic logic [W_W:0] clamp_w(input logic signed [ACC_W-1:0] v);
        logic [W_W:0] r;
        if (v < 0) begin
            r = {1'b1, W_W'(0)};
        end else if (v > W_MAX) begin
            r = {1'b1, {W_W{1'b1}}};
        end else begin
            r = {1'b0, v[W_W-1:0]};
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nx = state;
        cap_en   = 1'b0;
        err_en   = 1'b0;
        g0_en    = 1'b0;
        g1_en    = 1'b0;
        upd_en   = 1'b0;
        pass_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    cap_en   = 1'b1;
                    state_nx = S_ERR;
                end
            end
            S_ERR: begin
                err_en = 1'b1;
                if (err_c == '0) begin
                    pass_en  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_GRAD0;
                end
            end
            S_GRAD0: begin
                g0_en    = 1'b1;
                state_nx = S_GRAD1;
            end
            S_GRAD1: begin
                g1_en    = 1'b1;
                state_nx = S_UPD;
            end
            S_UPD: begin
                upd_en   = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Status flags follow the state the FSM is entering
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            busy_o <= (state_nx != S_IDLE);
            done_o <= (state_nx == S_DONE);
        end
    end

    // Operand snapshot taken at the accept edge
    always_ff @(posedge clk_i) begin
        if (cap_en) begin
            final_q <= final_i;
            init_q  <= init_i;
            x0_q    <= x0_i;
            x1_q    <= x1_i;
            w0_q    <= w0_i;
            w1_q    <= w1_i;
        end
    end

    assign err_c   = ERR_W'($signed({1'b0, final_q})) - ERR_W'($signed({1'b0, init_q}));
    assign mul_x_c = (state == S_GRAD0) ? x0_q : x1_q;
    assign prod_c  = G_W'(err_q) * G_W'($signed({1'b0, mul_x_c}));

    // Error and the two gradients share one multiplier across GRAD0/GRAD1
    always_ff @(posedge clk_i) begin
        if (err_en) begin
            err_q <= err_c;
        end
        if (g0_en) begin
            g0_q <= prod_c;
        end
        if (g1_en) begin
            g1_q <= prod_c;
        end
    end

    assign d0_c     = g0_q >>> LR_SHIFT;
    assign d1_c     = g1_q >>> LR_SHIFT;
    assign w0_new_c = ACC_W'($signed({1'b0, w0_q})) - ACC_W'(d0_c);
    assign w1_new_c = ACC_W'($signed({1'b0, w1_q})) - ACC_W'(d1_c);
    assign w0_cl_c  = clamp_w(w0_new_c);
    assign w1_cl_c  = clamp_w(w1_new_c);

    // Result registers are written only on UPD->DONE or the zero-error bypass
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w0_o  <= '0;
            w1_o  <= '0;
            sat_o <= 1'b0;
        end else if (upd_en) begin
            w0_o  <= w0_cl_c[W_W-1:0];
            w1_o  <= w1_cl_c[W_W-1:0];
            sat_o <= w0_cl_c[W_W] | w1_cl_c[W_W];
        end else if (pass_en) begin
            w0_o  <= w0_q;
            w1_o  <= w1_q;
            sat_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_backprop.sv
// Randomised self-checking bench for output_backprop against an integer model
// of the weight-update rule.
module tb_output_backprop;

    localparam int unsigned LR = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [22:0] final_i;
    logic [3:0]  init_i;
    logic [9:0]  x0_i, x1_i;
    logic [7:0]  w0_i, w1_i;
    logic [7:0]  w0_o, w1_o;
    logic        busy_o, done_o, sat_o;

    int n_checks = 0;
    int n_errors = 0;

    output_backprop #(.LR_SHIFT(LR)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .final_i (final_i),
        .init_i  (init_i),
        .x0_i    (x0_i),
        .x1_i    (x1_i),
        .w0_i    (w0_i),
        .w1_i    (w1_i),
        .w0_o    (w0_o),
        .w1_o    (w1_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sat_o   (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // floor(a / 2^LR) on plain integers
    function automatic longint floor_div(input longint a);
        longint d;
        d = longint'(1) << LR;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic void update_one(input longint err, input int x, input int w,
                                       output int w_new, output bit clamped);
        longint v;
        v = longint'(w) - floor_div(err * longint'(x));
        clamped = 1'b0;
        if (v < 0) begin
            w_new = 0; clamped = 1'b1;
        end else if (v > 255) begin
            w_new = 255; clamped = 1'b1;
        end else begin
            w_new = int'(v);
        end
    endfunction

    function automatic void model(input int f, input int t, input int x0, input int x1,
                                  input int w0, input int w1,
                                  output int ew0, output int ew1, output int esat,
                                  output int elat);
        longint err;
        bit c0, c1;
        err = longint'(f) - longint'(t);
        if (err == 0) begin
            ew0 = w0; ew1 = w1; esat = 0; elat = 1;
        end else begin
            update_one(err, x0, w0, ew0, c0);
            update_one(err, x1, w1, ew1, c1);
            esat = int'(c0 | c1);
            elat = 4;
        end
    endfunction

    task automatic drive(input int f, input int t, input int x0, input int x1,
                         input int w0, input int w1);
        final_i = 23'(f);
        init_i  = 4'(t);
        x0_i    = 10'(x0);
        x1_i    = 10'(x1);
        w0_i    = 8'(w0);
        w1_i    = 8'(w1);
    endtask

    task automatic garble();
        drive(int'($urandom_range(0, 8388607)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    // One isolated update from IDLE: accept, scramble inputs, wait for done_o
    task automatic run_op(input string tag, input int f, input int t, input int x0,
                          input int x1, input int w0, input int w1);
        int ew0, ew1, esat, elat, n;
        model(f, t, x0, x1, w0, w1, ew0, ew1, esat, elat);
        drive(f, t, x0, x1, w0, w1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        garble();
        check({tag, ".busy"}, busy_o, 1);
        n = 1;
        tick();
        while (!done_o && n < 10) begin
            tick();
            n++;
        end
        check({tag, ".lat"}, n, elat);
        check({tag, ".w0"}, w0_o, ew0);
        check({tag, ".w1"}, w1_o, ew1);
        check({tag, ".sat"}, sat_o, esat);
        tick();
        check({tag, ".done_pulse"}, done_o, 0);
        check({tag, ".idle"}, busy_o, 0);
        check({tag, ".hold_w0"}, w0_o, ew0);
    endtask

    initial begin
        int ew0, ew1, esat, elat;
        int f, t, x0, x1, w0, w1;
        bit seen_done;

        rst_i   = 1'b1;
        start_i = 1'b1;
        garble();
        tick();
        tick();
        check("rst.w0", w0_o, 0);
        check("rst.w1", w1_o, 0);
        check("rst.sat", sat_o, 0);
        check("rst.done", done_o, 0);
        check("rst.busy", busy_o, 0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        tick();

        run_op("v029", 10, 4, 2, 3, 128, 64);
        run_op("v030", 0, 9, 100, 0, 100, 77);
        run_op("v031", 1000, 0, 10, 1, 5, 200);
        run_op("v032", 7, 7, 513, 44, 91, 13);
        run_op("xzero", 8000000, 0, 0, 0, 17, 250);
        run_op("maxneg", 0, 15, 1023, 1023, 0, 255);

        for (int i = 0; i < 40; i++) begin
            t  = int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       f = t;
                1:       f = int'($urandom_range(0, 20));
                2:       f = int'($urandom_range(0, 8388607));
                default: f = int'($urandom_range(0, 2000));
            endcase
            x0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
            x1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
            w0 = int'($urandom_range(0, 255));
            w1 = int'($urandom_range(0, 255));
            run_op($sformatf("rnd%0d", i), f, t, x0, x1, w0, w1);
        end

        // Abort in GRAD1 with start held high: no pulse, no write, all cleared
        drive(500, 3, 7, 9, 40, 50);
        start_i = 1'b1;
        tick();
        garble();
        tick();
        garble();
        tick();
        check("abort.no_early_done", done_o, 0);
        check("abort.busy_before", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("abort.w0", w0_o, 0);
        check("abort.w1", w1_o, 0);
        check("abort.sat", sat_o, 0);
        check("abort.busy", busy_o, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_o) seen_done = 1'b1;
        end
        check("abort.no_done", seen_done, 0);
        check("abort.w0_kept", w0_o, 0);

        // Back-to-back with start held high: one result every 6 cycles
        start_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            t  = int'($urandom_range(0, 15));
            f  = int'($urandom_range(0, 3000));
            if (f == t) f = t + 1;
            x0 = int'($urandom_range(0, 1023));
            x1 = int'($urandom_range(0, 1023));
            w0 = int'($urandom_range(0, 255));
            w1 = int'($urandom_range(0, 255));
            model(f, t, x0, x1, w0, w1, ew0, ew1, esat, elat);
            drive(f, t, x0, x1, w0, w1);
            tick();
            for (int c = 1; c < 4; c++) begin
                garble();
                tick();
                check($sformatf("b2b%0d.c%0d.done", k, c), done_o, 0);
            end
            garble();
            tick();
            check($sformatf("b2b%0d.done", k), done_o, 1);
            check($sformatf("b2b%0d.w0", k), w0_o, ew0);
            check($sformatf("b2b%0d.w1", k), w1_o, ew1);
            check($sformatf("b2b%0d.sat", k), sat_o, esat);
            garble();
            tick();
            check($sformatf("b2b%0d.idle", k), busy_o, 0);
        end
        start_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
